mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, byte-address width; memory holds 2^ADDR_W bytes.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each ack (0 legal).
REQ-003 Parameter OUT_ADDR, default 8'hFF, address of the memory-mapped output port.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  1  initiator request, held high until ack.
REQ-008 we  input  1  1 = write, 0 = read; qualified by req.
REQ-009 addr  input  ADDR_W  byte address.
REQ-010 wdata  input  8  write data.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 rdata  output  8  read data, valid in the ack cycle.
REQ-013 port_out  output  8  last byte written to OUT_ADDR.
REQ-014 port_strobe  output  1  one-cycle pulse on each OUT_ADDR write.
REQ-015 dbg_addr  input  ADDR_W  bench peek address.
REQ-016 dbg_data  output  8  combinational memory[dbg_addr]; no side effects.

Function
REQ-017 FSM states are IDLE, WAIT and ACK; the reset state is IDLE.
REQ-018 IDLE: on req=1, latch we/addr/wdata, load wait counter with WAIT_CYCLES, and go to WAIT (to ACK if WAIT_CYCLES=0).
REQ-019 WAIT: decrement the counter each cycle and go to ACK when the counter reaches 1.
REQ-020 ACK: ack=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-021 Latency from the req-sampling edge to ack high is WAIT_CYCLES+1 cycles.
REQ-022 Back-to-back: a req still high in the IDLE cycle after ACK is a new request, so minimum spacing is WAIT_CYCLES+2 cycles.
REQ-023 Latched we/addr/wdata are used for the whole transaction; input changes after acceptance are ignored.
REQ-024 Write: memory[addr] is updated at the edge entering ACK, and a read in the same transaction slot never occurs.
REQ-025 Write to OUT_ADDR: update both memory and port_out, and pulse port_strobe coincident with ack.
REQ-026 Read: rdata loads memory[addr] at the edge entering ACK and holds until the next read completes; writes leave rdata unchanged.
REQ-027 Read of OUT_ADDR returns the memory byte, which equals port_out.
REQ-028 The wait counter is wide enough for WAIT_CYCLES and never wraps.
REQ-029 req=0 in IDLE is a no-op, and req is ignored in WAIT and ACK.
REQ-030 dbg_data reflects a write from the edge after which memory is updated.

Reset
REQ-031 Asserting reset forces the FSM to IDLE and sets ack=0, rdata=0, port_out=0, port_strobe=0 and the counter to 0.
REQ-032 Reset mid-transaction abandons the transaction, discards any pending write with memory unchanged, and emits no ack.
REQ-033 Memory contents are not cleared by reset.
REQ-034 After reset deasserts, the first request may be sampled at the next rising edge.

Verification
REQ-035 Write 8'h5A to 8'h10, then read 8'h10 with WAIT_CYCLES=2 -> each ack 3 cycles after req sampled, rdata=8'h5A, dbg_data(8'h10)=8'h5A.
REQ-036 Write 8'h2A to 8'hFF -> port_strobe and ack high for the same single cycle, port_out=8'h2A, and a read of 8'hFF returns 8'h2A.
REQ-037 req held high continuously with alternating addresses -> acks spaced exactly WAIT_CYCLES+2 cycles apart, with no missed or duplicate ack.
REQ-038 Change addr and wdata one cycle after acceptance -> write lands at the originally latched address and value.
REQ-039 Assert reset during WAIT of a write of 8'h77 to 8'h20 -> no ack, memory[8'h20] unchanged, and all outputs 0.
REQ-040 Build with WAIT_CYCLES=0 and read -> ack on the cycle after req is sampled, with correct rdata.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide memory slave with a fixed wait-state handshake and one memory-mapped output port.
module mem_responder #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0]  OUT_ADDR    = ADDR_W'(8'hFF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        wdata,
    output logic              ack,
    output logic [7:0]        rdata,
    output logic [7:0]        port_out,
    output logic              port_strobe,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32'(1) << ADDR_W;
    localparam int unsigned CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xact_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    xact_t             lat_q, lat_d;
    logic              enter_ack_c;
    logic              wr_c;
    logic              rd_c;
    logic              out_wr_c;

    logic [DATA_W-1:0] mem [DEPTH];

    // Next-state logic: accept in IDLE, count wait states, single ACK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    lat_d.we    = we;
                    lat_d.addr  = addr;
                    lat_d.wdata = wdata;
                    cnt_d       = CNT_W'(WAIT_CYCLES);
                    state_d     = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Transaction completes on the edge that enters ACK; lat_d covers the zero-wait case.
    always_comb begin
        enter_ack_c = (state_d == S_ACK) && (state_q != S_ACK);
        wr_c        = enter_ack_c && lat_d.we;
        rd_c        = enter_ack_c && !lat_d.we;
        out_wr_c    = wr_c && (lat_d.addr == OUT_ADDR);
    end

    // FSM state, wait counter and latched request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
        end
    end

    // Registered handshake, read data and output port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack         <= 1'b0;
            rdata       <= '0;
            port_out    <= '0;
            port_strobe <= 1'b0;
        end else begin
            ack         <= enter_ack_c;
            port_strobe <= out_wr_c;
            if (out_wr_c) begin
                port_out <= lat_d.wdata;
            end
            if (rd_c) begin
                rdata <= mem[lat_d.addr];
            end
        end
    end

    // Storage array is not reset; a write is suppressed while reset is asserted.
    always_ff @(posedge clk) begin
        if (wr_c && reset) begin
            mem[lat_d.addr] <= lat_d.wdata;
        end
    end

    // Side-effect-free peek port.
    assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build plus a zero-wait build.
module tb_mem_responder;

    logic       clk;
    logic       reset;

    logic       req, we;
    logic [7:0] addr, wdata, dbg_addr;
    logic       ack, port_strobe;
    logic [7:0] rdata, port_out, dbg_data;

    logic       req0, we0;
    logic [7:0] addr0, wdata0, dbg_addr0;
    logic       ack0, port_strobe0;
    logic [7:0] rdata0, port_out0, dbg_data0;

    int checks;
    int errors;

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2), .OUT_ADDR(8'hFF)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .rdata(rdata), .port_out(port_out), .port_strobe(port_strobe),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0), .OUT_ADDR(8'hFF)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .port_out(port_out0), .port_strobe(port_strobe0),
        .dbg_addr(dbg_addr0), .dbg_data(dbg_data0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and hold it until ack; lat counts samples after the accepting edge (0 = timeout).
    task automatic xact(input bit z, input logic w, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output logic strb);
        lat  = 0;
        rd   = '0;
        strb = 1'b0;
        if (z) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req = 1'b1; we = w; addr = a; wdata = d;
        end
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            tick();
            if ((z ? ack0 : ack) === 1'b1) begin
                lat  = k;
                rd   = z ? rdata0 : rdata;
                strb = z ? port_strobe0 : port_strobe;
            end
        end
        if (z) req0 = 1'b0;
        else   req  = 1'b0;
        tick();
        check("ack_single_cycle", 32'(z ? ack0 : ack), 32'd0);
    endtask

    int         lat;
    logic [7:0] rd;
    logic       strb;
    int         nack;
    int         pos [8];

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; dbg_addr = '0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; dbg_addr0 = '0;
        foreach (pos[i]) pos[i] = 0;

        tick();
        tick();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_port_out", 32'(port_out), 32'd0);
        check("rst_port_strobe", 32'(port_strobe), 32'd0);
        check("rst_ack0", 32'(ack0), 32'd0);
        reset = 1'b1;

        // Basic write then read back
        xact(1'b0, 1'b1, 8'h10, 8'h5A, lat, rd, strb);
        check("wr10_latency", 32'(lat), 32'd3);
        check("wr10_no_strobe", 32'(strb), 32'd0);
        dbg_addr = 8'h10; #1;
        check("dbg_10", 32'(dbg_data), 32'h5A);
        xact(1'b0, 1'b0, 8'h10, 8'h00, lat, rd, strb);
        check("rd10_latency", 32'(lat), 32'd3);
        check("rd10_rdata", 32'(rd), 32'h5A);

        // Output port write
        xact(1'b0, 1'b1, 8'hFF, 8'h2A, lat, rd, strb);
        check("wrff_latency", 32'(lat), 32'd3);
        check("wrff_strobe_with_ack", 32'(strb), 32'd1);
        check("wrff_strobe_single", 32'(port_strobe), 32'd0);
        check("wrff_port_out", 32'(port_out), 32'h2A);
        check("wrff_rdata_held", 32'(rdata), 32'h5A);
        xact(1'b0, 1'b0, 8'hFF, 8'h00, lat, rd, strb);
        check("rdff_rdata", 32'(rd), 32'h2A);
        check("rdff_no_strobe", 32'(strb), 32'd0);

        // Back-to-back writes with req held high, address alternating per transaction
        nack = 0;
        req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 8'hA0;
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (ack === 1'b1) begin
                if (nack < 8) pos[nack] = k;
                nack++;
                addr  = (nack % 2 == 1) ? 8'h31 : 8'h30;
                wdata = 8'hA0 + 8'(nack);
                if (nack == 4) req = 1'b0;
            end
        end
        check("b2b_count", 32'(nack), 32'd4);
        check("b2b_ack0", 32'(pos[0]), 32'd3);
        check("b2b_ack1", 32'(pos[1]), 32'd7);
        check("b2b_ack2", 32'(pos[2]), 32'd11);
        check("b2b_ack3", 32'(pos[3]), 32'd15);
        dbg_addr = 8'h30; #1;
        check("b2b_mem30", 32'(dbg_data), 32'hA2);
        dbg_addr = 8'h31; #1;
        check("b2b_mem31", 32'(dbg_data), 32'hA3);

        // Inputs changed after acceptance must be ignored
        xact(1'b0, 1'b1, 8'h41, 8'h11, lat, rd, strb);
        req = 1'b1; we = 1'b1; addr = 8'h40; wdata = 8'h3C;
        tick();
        addr = 8'h41; wdata = 8'h99;
        lat = 0;
        for (int k = 2; k <= 20 && lat == 0; k++) begin
            tick();
            if (ack === 1'b1) lat = k;
        end
        req = 1'b0;
        tick();
        check("latch_latency", 32'(lat), 32'd3);
        dbg_addr = 8'h40; #1;
        check("latch_mem40", 32'(dbg_data), 32'h3C);
        dbg_addr = 8'h41; #1;
        check("latch_mem41", 32'(dbg_data), 32'h11);

        // Reset in the middle of a pending write
        xact(1'b0, 1'b1, 8'h20, 8'h33, lat, rd, strb);
        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h77;
        tick();
        tick();
        check("midrst_no_early_ack", 32'(ack), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_port_out", 32'(port_out), 32'd0);
        check("midrst_port_strobe", 32'(port_strobe), 32'd0);
        req = 1'b0;
        tick();
        check("midrst_held_ack", 32'(ack), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        check("midrst_after_ack", 32'(ack), 32'd0);
        dbg_addr = 8'h20; #1;
        check("midrst_mem20", 32'(dbg_data), 32'h33);
        dbg_addr = 8'h10; #1;
        check("mem_survives_reset", 32'(dbg_data), 32'h5A);
        xact(1'b0, 1'b0, 8'h20, 8'h00, lat, rd, strb);
        check("post_rst_latency", 32'(lat), 32'd3);
        check("post_rst_rdata", 32'(rd), 32'h33);

        // Zero wait-state build
        xact(1'b1, 1'b1, 8'h05, 8'h55, lat, rd, strb);
        check("w0_wr_latency", 32'(lat), 32'd1);
        xact(1'b1, 1'b0, 8'h05, 8'h00, lat, rd, strb);
        check("w0_rd_latency", 32'(lat), 32'd1);
        check("w0_rd_rdata", 32'(rd), 32'h55);
        dbg_addr0 = 8'h05; #1;
        check("w0_dbg_05", 32'(dbg_data0), 32'h55);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
